// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared codes for the pipeline hazard controller: forward-select encoding,
// FSM state encoding and the register number of the PC.
package pipeline_hazard_controller_pkg;

  // Forward select: where the EX stage takes an operand from.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file (no forwarding)
  localparam logic [1:0] FWD_EX  = 2'b01;  // EX-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage result
  localparam logic [1:0] FWD_WB  = 2'b11;  // WB-stage result

  // R15 is the PC; it is read through its own path and never forwarded.
  localparam logic [3:0] REG_PC = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle for the hazard controller. The controller uses
// the slave modport (pipeline status in, enables/selects out); the pipeline
// or a bench uses the master modport. There is no handshake in this bundle:
// every input is sampled as a level each cycle and every output is a
// combinational level valid for the current cycle.
interface pipeline_hazard_controller_if #(
  parameter int STALL_CNT_W = 16
);
  import pipeline_hazard_controller_pkg::*;

  // ID-stage sources
  logic [3:0] ID_Rn;
  logic [3:0] ID_Rm;
  logic [3:0] ID_Rd;
  logic       ID_use_Rn;
  logic       ID_use_Rm;
  logic       ID_use_Rd;
  logic       ID_B_taken;

  // Destinations of later stages
  logic [3:0] EX_Rd;
  logic [3:0] MEM_Rd;
  logic [3:0] WB_Rd;
  logic       EX_RF_enable;
  logic       MEM_RF_enable;
  logic       WB_RF_enable;
  logic       EX_Load_Inst;

  // Data-memory status
  logic       MEM_enable;
  logic       dmem_ready;

  // Controls back to the pipeline
  logic       PC_LE;
  logic       IFID_LE;
  logic       IDEX_LE;
  logic       EXMEM_LE;
  logic       MEMWB_LE;
  logic       select_mux;
  logic       IFID_flush;
  logic [1:0] FWD_A;
  logic [1:0] FWD_B;
  logic [1:0] FWD_C;
  logic       mem_error;
  logic [STALL_CNT_W-1:0] stall_count;

  // Debug view of the controller FSM
  state_t     state;

  modport slave (
    input  ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_B_taken,
    input  EX_Rd, MEM_Rd, WB_Rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
    input  EX_Load_Inst, MEM_enable, dmem_ready,
    output PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, MEMWB_LE, select_mux, IFID_flush,
    output FWD_A, FWD_B, FWD_C, mem_error, stall_count, state
  );

  modport master (
    output ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_B_taken,
    output EX_Rd, MEM_Rd, WB_Rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
    output EX_Load_Inst, MEM_enable, dmem_ready,
    input  PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, MEMWB_LE, select_mux, IFID_flush,
    input  FWD_A, FWD_B, FWD_C, mem_error, stall_count, state
  );

endinterface

// File: rtl/pipeline_hazard_controller_fwd_select.sv
// Forward-select for one EX operand: youngest matching writer wins
// (EX, then MEM, then WB). A load still in EX has no data yet, so its match
// yields the register file; the load-use stall covers that case.
module pipeline_hazard_controller_fwd_select
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [3:0] src,
  input  logic       use_src,
  input  logic [3:0] ex_rd,
  input  logic       ex_rf_en,
  input  logic       ex_load,
  input  logic [3:0] mem_rd,
  input  logic       mem_rf_en,
  input  logic [3:0] wb_rd,
  input  logic       wb_rf_en,
  output logic [1:0] fwd
);

  // Priority match from youngest to oldest producer.
  always_comb begin
    fwd = FWD_RF;
    if (use_src && (src != REG_PC)) begin
      if (ex_rf_en && (ex_rd == src)) begin
        fwd = ex_load ? FWD_RF : FWD_EX;
      end else if (mem_rf_en && (mem_rd == src)) begin
        fwd = FWD_MEM;
      end else if (wb_rf_en && (wb_rd == src)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: load enables,
// NOP-insert select, IF/ID flush, EX forwarding selects, data-memory wait
// freeze with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 15,
  parameter int STALL_CNT_W  = 16
) (
  input  logic CLK,
  input  logic CLR,
  pipeline_hazard_controller_if.slave hz
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  state_t                 state;
  logic [7:0]             wait_cnt;
  logic                   mem_error_q;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic       mem_wait;
  logic       load_use;
  logic       pc_le;
  logic       ifid_le;
  logic       late_le;
  logic       sel_nop;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [1:0] fwd_c;

  assign mem_wait = hz.MEM_enable & ~hz.dmem_ready;

  // A load in EX whose destination an ID source needs: one bubble is required.
  always_comb begin
    load_use = 1'b0;
    if (hz.EX_Load_Inst && hz.EX_RF_enable) begin
      if (hz.ID_use_Rn && (hz.ID_Rn != REG_PC) && (hz.EX_Rd == hz.ID_Rn)) load_use = 1'b1;
      if (hz.ID_use_Rm && (hz.ID_Rm != REG_PC) && (hz.EX_Rd == hz.ID_Rm)) load_use = 1'b1;
      if (hz.ID_use_Rd && (hz.ID_Rd != REG_PC) && (hz.EX_Rd == hz.ID_Rd)) load_use = 1'b1;
    end
  end

  // Control outputs from state and inputs; priority mem_wait > load_use > branch.
  always_comb begin
    pc_le   = 1'b1;
    ifid_le = 1'b1;
    late_le = 1'b1;
    sel_nop = 1'b0;
    flush   = 1'b0;
    if (CLR) begin
      if (state == ST_ERROR) begin
        pc_le   = 1'b0;
        ifid_le = 1'b0;
        late_le = 1'b0;
        sel_nop = 1'b1;
      end else if (mem_wait) begin
        pc_le   = 1'b0;
        ifid_le = 1'b0;
        late_le = 1'b0;
      end else if (load_use) begin
        pc_le   = 1'b0;
        ifid_le = 1'b0;
        sel_nop = 1'b1;
      end else if (hz.ID_B_taken) begin
        flush   = 1'b1;
      end
    end
  end

  pipeline_hazard_controller_fwd_select u_fwd_a (
    .src(hz.ID_Rn), .use_src(hz.ID_use_Rn),
    .ex_rd(hz.EX_Rd), .ex_rf_en(hz.EX_RF_enable), .ex_load(hz.EX_Load_Inst),
    .mem_rd(hz.MEM_Rd), .mem_rf_en(hz.MEM_RF_enable),
    .wb_rd(hz.WB_Rd), .wb_rf_en(hz.WB_RF_enable),
    .fwd(fwd_a)
  );

  pipeline_hazard_controller_fwd_select u_fwd_b (
    .src(hz.ID_Rm), .use_src(hz.ID_use_Rm),
    .ex_rd(hz.EX_Rd), .ex_rf_en(hz.EX_RF_enable), .ex_load(hz.EX_Load_Inst),
    .mem_rd(hz.MEM_Rd), .mem_rf_en(hz.MEM_RF_enable),
    .wb_rd(hz.WB_Rd), .wb_rf_en(hz.WB_RF_enable),
    .fwd(fwd_b)
  );

  pipeline_hazard_controller_fwd_select u_fwd_c (
    .src(hz.ID_Rd), .use_src(hz.ID_use_Rd),
    .ex_rd(hz.EX_Rd), .ex_rf_en(hz.EX_RF_enable), .ex_load(hz.EX_Load_Inst),
    .mem_rd(hz.MEM_Rd), .mem_rf_en(hz.MEM_RF_enable),
    .wb_rd(hz.WB_Rd), .wb_rf_en(hz.WB_RF_enable),
    .fwd(fwd_c)
  );

  assign hz.PC_LE       = pc_le;
  assign hz.IFID_LE     = ifid_le;
  assign hz.IDEX_LE     = late_le;
  assign hz.EXMEM_LE    = late_le;
  assign hz.MEMWB_LE    = late_le;
  assign hz.select_mux  = sel_nop;
  assign hz.IFID_flush  = flush;
  assign hz.FWD_A       = CLR ? fwd_a : FWD_RF;
  assign hz.FWD_B       = CLR ? fwd_b : FWD_RF;
  assign hz.FWD_C       = CLR ? fwd_c : FWD_RF;
  assign hz.mem_error   = mem_error_q;
  assign hz.stall_count = stall_cnt;
  assign hz.state       = state;

  // FSM with memory-wait counter, sticky timeout flag and stall counter.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state       <= ST_RUN;
      wait_cnt    <= 8'd0;
      mem_error_q <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (!pc_le && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (mem_wait) begin
            wait_cnt <= 8'd1;
            if (TIMEOUT_CNT <= 8'd1) begin
              state       <= ST_ERROR;
              mem_error_q <= 1'b1;
            end else begin
              state <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_wait) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt >= TIMEOUT_CNT - 8'd1) begin
              state       <= ST_ERROR;
              mem_error_q <= 1'b1;
            end
          end else begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
